// File: rtl/sprites_pkg.sv
// Shared types and constants for the sprite pixel pipeline.
// The per-pixel record carried through the shifter lives here so the
// merge cell and the shifter agree on field layout.
package sprites_pkg;

   // Pixels per sprite tile row; the shifter is built around this width.
   localparam int SPR_TILE_W  = 8;

   // Width of the OAM slot index carried with each pixel.
   localparam int SPR_INDEX_W = 4;

   // One resolved sprite pixel as held in a shifter slot.
   typedef struct packed {
      logic [1:0]             color;
      logic                   pal;
      logic                   prio;
      logic [2:0]             cgb_pal;
      logic [SPR_INDEX_W-1:0] index;
   } spr_pix_t;

   // An empty slot: colour 0 is transparent and every attribute is cleared.
   localparam spr_pix_t SPR_PIX_TRANSPARENT = '0;

   // Colour of pixel j of a tile row. Without flip, bit 7 is the leftmost
   // pixel; with flip the row is mirrored so bit 0 becomes the leftmost.
   function automatic logic [1:0] spr_tile_pixel(
      input logic [7:0] tile0,
      input logic [7:0] tile1,
      input logic       xflip,
      input logic [2:0] j
   );
      logic [2:0] bit_sel;
      bit_sel = xflip ? j : (3'd7 - j);
      return {tile1[bit_sel], tile0[bit_sel]};
   endfunction

endpackage

// File: rtl/sprites_pixel_merge.sv
// Per-slot overlap resolver: decides whether an incoming sprite pixel
// replaces the pixel already held in a shifter slot. Purely combinational.
// conflict flags a slot where both pixels are opaque, whichever one wins.
module sprites_pixel_merge
   import sprites_pkg::*;
(
   input  logic     cgb_mode,
   input  logic     cand_en,
   input  spr_pix_t existing,
   input  spr_pix_t candidate,
   output spr_pix_t result,
   output logic     conflict
);

   logic cand_opaque;
   logic exist_opaque;

   assign cand_opaque  = cand_en && (candidate.color != 2'd0);
   assign exist_opaque = (existing.color != 2'd0);

   // Winner select: transparent candidates never write, empty slots always
   // accept, and between two opaque pixels only a strictly lower index in
   // CGB mode displaces the resident one (DMG keeps the earlier sprite).
   always_comb begin
      result   = existing;
      conflict = 1'b0;
      if (cand_opaque) begin
         if (!exist_opaque) begin
            result = candidate;
         end else begin
            conflict = 1'b1;
            if (cgb_mode && (candidate.index < existing.index)) begin
               result = candidate;
            end
         end
      end
   end

endmodule

// File: rtl/sprites_pixel_shifter.sv
// Sprite pixel shifter: holds up to one tile width of pending sprite pixels,
// merges newly matched sprites into it with DMG or CGB overlap priority,
// and presents slot 0 to the BG/sprite mixer each pixel clock.
// Outputs come straight from slot-0 registers (no input-to-output path).
// Optional build macro SPRITES_PIXEL_SHIFTER_OVERRIDE_CNT_EN adds a
// saturating override_cnt output counting opaque-over-opaque overlaps.
module sprites_pixel_shifter
   import sprites_pkg::*;
#(
   parameter int SLOTS   = SPR_TILE_W,   // only the tile width is supported
   parameter int INDEX_W = SPR_INDEX_W   // must match the packed index field
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               ce,
   input  logic               cgb_mode,
   input  logic               shift,
   input  logic               load,
   input  logic [2:0]         skip,
   input  logic [7:0]         tile0,
   input  logic [7:0]         tile1,
   input  logic               xflip,
   input  logic [INDEX_W-1:0] index_in,
   input  logic               pal_in,
   input  logic               prio_in,
   input  logic [2:0]         cgb_pal_in,
   output logic [1:0]         pix_color,
   output logic               pix_pal,
   output logic               pix_prio,
   output logic [2:0]         pix_cgb_pal,
   output logic [INDEX_W-1:0] pix_index,
   output logic               pix_valid
`ifdef SPRITES_PIXEL_SHIFTER_OVERRIDE_CNT_EN
   ,
   output logic [7:0]         override_cnt
`endif
);

   // Slot state and the intermediate arrays of the shift/place/merge path.
   spr_pix_t   slot_reg     [SLOTS];
   spr_pix_t   slot_next    [SLOTS];
   spr_pix_t   shifted      [SLOTS];
   spr_pix_t   candidate    [SLOTS];
   logic       cand_en      [SLOTS];
   logic [3:0] src_idx      [SLOTS];
   logic       conflict     [SLOTS];
   logic [1:0] tile_color   [SPR_TILE_W];

   genvar gi;

   // Unpack the incoming tile row into per-pixel colours, honouring xflip.
   generate
      for (gi = 0; gi < SPR_TILE_W; gi++) begin : g_unpack
         assign tile_color[gi] = spr_tile_pixel(tile0, tile1, xflip, 3'(gi));
      end
   endgenerate

   // Advance the array by one pixel when shift is set; the far end refills
   // with a transparent slot.
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_shift
         if (gi == SLOTS - 1) begin : g_last
            assign shifted[gi] = shift ? SPR_PIX_TRANSPARENT : slot_reg[gi];
         end else begin : g_mid
            assign shifted[gi] = shift ? slot_reg[gi+1] : slot_reg[gi];
         end
      end
   endgenerate

   // Place the tile: slot k receives pixel k+skip. Pixels shifted past the
   // right end of the tile (k+skip >= tile width) do not exist, so the
   // trailing skip slots get no candidate.
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_place
         assign src_idx[gi] = 4'(gi) + {1'b0, skip};
         assign cand_en[gi] = load && (src_idx[gi] < 4'(SPR_TILE_W));

         // Build the candidate record for this slot from the sprite attributes.
         always_comb begin
            candidate[gi]         = SPR_PIX_TRANSPARENT;
            candidate[gi].pal     = pal_in;
            candidate[gi].prio    = prio_in;
            candidate[gi].cgb_pal = cgb_pal_in;
            candidate[gi].index   = index_in;
            if (cand_en[gi]) begin
               candidate[gi].color = tile_color[src_idx[gi][2:0]];
            end
         end
      end
   endgenerate

   // One overlap resolver per slot, working on the post-shift array.
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_merge
         sprites_pixel_merge u_merge (
            .cgb_mode  (cgb_mode),
            .cand_en   (cand_en[gi]),
            .existing  (shifted[gi]),
            .candidate (candidate[gi]),
            .result    (slot_next[gi]),
            .conflict  (conflict[gi])
         );
      end
   endgenerate

   // Slot registers: reset clears everything, otherwise update only on ce.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SLOTS; k++) begin
            slot_reg[k] <= SPR_PIX_TRANSPARENT;
         end
      end else if (ce) begin
         for (int k = 0; k < SLOTS; k++) begin
            slot_reg[k] <= slot_next[k];
         end
      end
   end

   // Present slot 0 to the mixer.
   assign pix_color   = slot_reg[0].color;
   assign pix_pal     = slot_reg[0].pal;
   assign pix_prio    = slot_reg[0].prio;
   assign pix_cgb_pal = slot_reg[0].cgb_pal;
   assign pix_index   = slot_reg[0].index;
   assign pix_valid   = (slot_reg[0].color != 2'd0);

`ifdef SPRITES_PIXEL_SHIFTER_OVERRIDE_CNT_EN
   logic [7:0] override_cnt_reg;
   logic [7:0] override_cnt_next;
   logic [3:0] conflict_pop;
   logic [8:0] override_sum;

   // Count overlapping slots this cycle and add them with saturation at 255.
   always_comb begin
      conflict_pop = 4'd0;
      for (int k = 0; k < SLOTS; k++) begin
         conflict_pop = conflict_pop + {3'd0, conflict[k]};
      end
      override_sum      = {1'b0, override_cnt_reg} + {5'd0, conflict_pop};
      override_cnt_next = override_sum[8] ? 8'hFF : override_sum[7:0];
   end

   // Overlap counter register, gated by ce like the slots.
   always_ff @(posedge clk) begin
      if (reset) begin
         override_cnt_reg <= 8'd0;
      end else if (ce) begin
         override_cnt_reg <= override_cnt_next;
      end
   end

   assign override_cnt = override_cnt_reg;
`else
   // Without the counter the per-slot conflict flags have no consumer.
   logic conflict_unused;

   // Fold the unused conflict flags so they are visibly terminated.
   always_comb begin
      conflict_unused = 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
         conflict_unused = conflict_unused | conflict[k];
      end
   end
`endif

endmodule
